// File: rtl/seq_divider.sv
// seq_divider
//   Sequential unsigned radix-2 restoring divider. Divides a 2*NUMBIT-bit
//   dividend by a NUMBIT-bit divisor, producing one quotient bit per cycle.
//   Overflow (quotient wider than NUMBIT bits) and divide-by-zero are detected
//   up front and finish in a single cycle.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          dividend/divisor valid
//   in_ready   out  1          divider can accept an operation (IDLE only)
//   dividend   in   2*NUMBIT   unsigned dividend
//   divisor    in   NUMBIT     unsigned divisor
//   out_valid  out  1          result valid, held until out_ready
//   out_ready  in   1          consumer accepts result
//   quotient   out  NUMBIT     unsigned quotient ('1 on ovf/dz)
//   remainder  out  NUMBIT     unsigned remainder ('0 on ovf/dz)
//   ovf        out  1          quotient does not fit (includes divide-by-zero)
//   dz         out  1          divisor was zero
module seq_divider #(
  parameter int unsigned NUMBIT = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*NUMBIT-1:0]   dividend,
  input  logic [NUMBIT-1:0]     divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUMBIT-1:0]     quotient,
  output logic [NUMBIT-1:0]     remainder,
  output logic                  ovf,
  output logic                  dz
);

  localparam int unsigned CW = (NUMBIT > 1) ? $clog2(NUMBIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [NUMBIT-1:0] rem_r;    // partial remainder (always < divisor)
  logic [NUMBIT-1:0] lo_r;     // low dividend half, consumed MSB first
  logic [NUMBIT-1:0] dvs_r;    // latched divisor
  logic [CW-1:0]     count;

  logic [NUMBIT-1:0] upper;
  logic [NUMBIT:0]   shifted;
  logic              qbit;
  logic [NUMBIT-1:0] rem_next;

  assign upper = dividend[2*NUMBIT-1:NUMBIT];

  always_comb begin
    in_ready = rst_n && (state == IDLE);
  end

  // The partial remainder is kept N bits wide: it is always below the
  // divisor, so the extra top bit of the N+1-bit remainder is never set.
  // When the trial subtraction succeeds the true result is < divisor, so an
  // N-bit modular subtract gives the exact value.
  always_comb begin
    shifted  = {rem_r, lo_r[NUMBIT-1]};
    qbit     = (shifted >= {1'b0, dvs_r});
    rem_next = qbit ? (shifted[NUMBIT-1:0] - dvs_r) : shifted[NUMBIT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      rem_r     <= '0;
      lo_r      <= '0;
      dvs_r     <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              dz        <= 1'b1;
              ovf       <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (upper >= divisor) begin
              dz        <= 1'b0;
              ovf       <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              dz        <= 1'b0;
              ovf       <= 1'b0;
              rem_r     <= upper;
              lo_r      <= dividend[NUMBIT-1:0];
              dvs_r     <= divisor;
              quotient  <= '0;
              count     <= CW'(NUMBIT - 1);
              state     <= RUN;
            end
          end
        end

        RUN: begin
          // quotient doubles as the shift register; out_valid is low here so
          // the intermediate bits are never presented as a result.
          rem_r    <= rem_next;
          lo_r     <= lo_r << 1;
          quotient <= {quotient[NUMBIT-2:0], qbit};
          if (count == '0) begin
            remainder <= rem_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Scoreboard bench for seq_divider with NUMBIT=11. Expected results are
//   produced by a behavioural divide model when an operation is driven and
//   compared when the divider presents its result.
module tb_seq_divider;

  localparam int unsigned N = 11;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         ovf;
    logic         dz;
  } res_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           ovf;
  logic           dz;

  int   n_cmp;
  int   n_fail;
  res_t sb[$];

  seq_divider #(.NUMBIT(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    res_t m;
    if (b == '0) begin
      m.q = '1; m.r = '0; m.ovf = 1'b1; m.dz = 1'b1;
    end else if (a[2*N-1:N] >= b) begin
      m.q = '1; m.r = '0; m.ovf = 1'b1; m.dz = 1'b0;
    end else begin
      m.q = N'(a / b); m.r = N'(a % b); m.ovf = 1'b0; m.dz = 1'b0;
    end
    return m;
  endfunction

  function automatic res_t observed();
    return {quotient, remainder, ovf, dz};
  endfunction

  // Drive one operation and wait (bounded) for the accepting edge.
  task automatic send(input logic [2*N-1:0] a, input logic [N-1:0] b, output bit ok);
    sb.push_back(model(a, b));
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_out(output res_t obs, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = observed();
  endtask

  task automatic handshake();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    n_cmp++;
    if (observed() !== res_t'(0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", observed());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    bit ok; res_t obs, want; int lat;
    send(22'd1000, 11'd7, ok);
    wait_out(obs, lat);
    want = sb.pop_front();
    n_cmp++;
    if (!ok || obs !== want) begin
      n_fail++;
      $display("FAIL basic_1000_7: ok=%b got %h want %h", ok, obs, want);
    end
    n_cmp++;
    if (lat !== N) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", lat, N);
    end
    handshake();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_boundaries();
    bit ok; res_t obs, want; int lat;
    logic [2*N-1:0] a_tab [4] = '{22'd4190209, 22'd0, 22'd1500, 22'd2047};
    logic [N-1:0]   b_tab [4] = '{11'd2047, 11'd5, 11'd1, 11'd2047};
    for (int i = 0; i < 4; i++) begin
      send(a_tab[i], b_tab[i], ok);
      wait_out(obs, lat);
      want = sb.pop_front();
      n_cmp++;
      if (!ok || obs !== want || lat !== N) begin
        n_fail++;
        $display("FAIL boundary_%0d: ok=%b lat=%0d got %h want %h lat %0d", i, ok, lat, obs, want, N);
      end
      handshake();
    end
  endtask

  task automatic test_errors();
    bit ok; res_t obs, want; int lat;
    send(22'd1234, 11'd0, ok);
    wait_out(obs, lat);
    want = sb.pop_front();
    n_cmp++;
    if (!ok || obs !== want) begin
      n_fail++;
      $display("FAIL div_zero: ok=%b got %h want %h", ok, obs, want);
    end
    n_cmp++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL div_zero_latency: edges after accept got %0d want 0", lat);
    end
    handshake();

    send(22'd10240, 11'd5, ok);
    wait_out(obs, lat);
    want = sb.pop_front();
    n_cmp++;
    if (!ok || obs !== want || lat !== 0) begin
      n_fail++;
      $display("FAIL overflow: ok=%b lat=%0d got %h want %h", ok, lat, obs, want);
    end
    handshake();

    send(22'd10239, 11'd5, ok);
    wait_out(obs, lat);
    want = sb.pop_front();
    n_cmp++;
    if (!ok || obs !== want || lat !== N) begin
      n_fail++;
      $display("FAIL ovf_cleared: ok=%b lat=%0d got %h want %h", ok, lat, obs, want);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok; res_t obs, want, held; int lat; int bad;
    out_ready = 1'b0;
    send(22'd1000, 11'd7, ok);
    // Next operation is offered immediately and held throughout.
    dividend = 22'd500;
    divisor  = 11'd3;
    in_valid = 1'b1;
    wait_out(obs, lat);
    want = sb.pop_front();
    n_cmp++;
    if (!ok || obs !== want) begin
      n_fail++;
      $display("FAIL bp_result: ok=%b got %h want %h", ok, obs, want);
    end
    held = obs;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (observed() !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles want 0", bad);
    end
    sb.push_back(model(22'd500, 11'd3));
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_reaccept: in_ready=%b want 0", in_ready);
    end
    wait_out(obs, lat);
    want = sb.pop_front();
    n_cmp++;
    if (obs !== want || lat !== N) begin
      n_fail++;
      $display("FAIL bp_second: lat=%0d got %h want %h lat %0d", lat, obs, want, N);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    bit ok; res_t obs, want; int lat; int seen;
    send(22'd1000, 11'd7, ok);
    void'(sb.pop_back());
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abort: ok=%b out_valid=%b in_ready=%b want 1 0 0", ok, out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_result: out_valid seen %0d cycles want 0", seen);
    end
    send(22'd12345, 11'd100, ok);
    wait_out(obs, lat);
    want = sb.pop_front();
    n_cmp++;
    if (!ok || obs !== want || lat !== N) begin
      n_fail++;
      $display("FAIL midreset_next_op: ok=%b lat=%0d got %h want %h", ok, lat, obs, want);
    end
    handshake();
  endtask

  task automatic test_random();
    bit ok; res_t obs, want; int lat;
    logic [N-1:0] a, b;
    for (int i = 0; i < 3000; i++) begin
      a = N'($urandom_range(0, 2047));
      b = N'($urandom_range(1, 2047));
      send((2*N)'(a) * (2*N)'(b), b, ok);
      void'(sb.pop_back());
      sb.push_back('{q: a, r: '0, ovf: 1'b0, dz: 1'b0});
      wait_out(obs, lat);
      want = sb.pop_front();
      n_cmp++;
      if (!ok || obs !== want) begin
        n_fail++;
        $display("FAIL random_%0d: a=%0d b=%0d ok=%b got %h want %h", i, a, b, ok, obs, want);
      end
      handshake();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
